// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port owner: zero-fills x1..x(NREGS-1) after reset or init_req,
// then arbitrates write-back between requester A (ALU) and requester B (load unit).
module regfile_wb_arbiter #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NREGS      = 32,
    parameter int unsigned FIXED_PRIO = 0,
    localparam int unsigned AW        = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            init_req,
    input  logic            a_valid,
    output logic            a_ready,
    input  logic [AW-1:0]   a_rd,
    input  logic [XLEN-1:0] a_data,
    input  logic            b_valid,
    output logic            b_ready,
    input  logic [AW-1:0]   b_rd,
    input  logic [XLEN-1:0] b_data,
    output logic            rf_we,
    output logic [AW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            init_done
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(NREGS - 1);
    localparam logic          LG_A      = 1'b0;
    localparam logic          LG_B      = 1'b1;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [AW-1:0]   cnt;
    logic [AW-1:0]   cnt_nxt;
    logic            last_grant;
    logic            last_grant_nxt;
    logic            we_nxt;
    logic [AW-1:0]   waddr_nxt;
    logic [XLEN-1:0] wdata_nxt;
    logic            done_nxt;
    logic            grant_a;
    logic            grant_b;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT: if (cnt == LAST_ADDR) state_nxt = ST_RUN;
            ST_RUN:  if (init_req)         state_nxt = ST_INIT;
            default:                       state_nxt = ST_INIT;
        endcase
    end

    // Grant: A wins a tie under fixed priority, or when B was served last
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (state == ST_RUN && !init_req) begin
            grant_a = a_valid && (!b_valid || FIXED_PRIO != 0 || last_grant == LG_B);
            grant_b = b_valid && !grant_a;
        end
    end

    // Output / datapath next values
    always_comb begin
        a_ready        = grant_a;
        b_ready        = grant_b;
        cnt_nxt        = cnt;
        last_grant_nxt = last_grant;
        we_nxt         = 1'b0;
        waddr_nxt      = rf_waddr;
        wdata_nxt      = rf_wdata;
        done_nxt       = init_done;
        case (state)
            ST_INIT: begin
                we_nxt    = 1'b1;
                waddr_nxt = cnt;
                wdata_nxt = '0;
                cnt_nxt   = cnt + AW'(1);
                if (cnt == LAST_ADDR) done_nxt = 1'b1;
            end
            ST_RUN: begin
                if (init_req) begin
                    cnt_nxt  = AW'(1);
                    done_nxt = 1'b0;
                end else if (grant_a) begin
                    we_nxt         = (a_rd != '0);
                    waddr_nxt      = a_rd;
                    wdata_nxt      = a_data;
                    last_grant_nxt = LG_A;
                end else if (grant_b) begin
                    we_nxt         = (b_rd != '0);
                    waddr_nxt      = b_rd;
                    wdata_nxt      = b_data;
                    last_grant_nxt = LG_B;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= AW'(1);
            last_grant <= LG_B;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            init_done  <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            last_grant <= last_grant_nxt;
            rf_we      <= we_nxt;
            rf_waddr   <= waddr_nxt;
            rf_wdata   <= wdata_nxt;
            init_done  <= done_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus constrained-random traffic,
// all cycles checked against a queue-based reference model of the write-back rules.
module tb_regfile_wb_arbiter;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned AW    = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            init_req;
    logic            a_valid, b_valid;
    logic            a_ready, b_ready;
    logic [AW-1:0]   a_rd, b_rd;
    logic [XLEN-1:0] a_data, b_data;
    logic            rf_we;
    logic [AW-1:0]   rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic            init_done;

    regfile_wb_arbiter #(.XLEN(XLEN), .NREGS(NREGS), .FIXED_PRIO(0)) dut (
        .clk(clk), .rst_n(rst_n), .init_req(init_req),
        .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .init_done(init_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: pending sweep addresses, expected registered outputs, last winner
    int              sweep_q[$];
    bit              last_b;
    logic            exp_we;
    logic [AW-1:0]   exp_waddr;
    logic [XLEN-1:0] exp_wdata;
    logic            exp_done;
    logic            exp_ar, exp_br;
    logic            last_ar, last_br;
    string           dut_log;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_log(input string tag, input string exp);
        checks++;
        assert (dut_log == exp) else begin
            errors++;
            $error("FAIL %s: observed grants='%s' expected='%s'", tag, dut_log, exp);
        end
    endtask

    task automatic model_fill();
        sweep_q.delete();
        for (int i = 1; i < int'(NREGS); i++) sweep_q.push_back(i);
    endtask

    task automatic model_reset();
        model_fill();
        last_b    = 1'b1;
        exp_we    = 1'b0;
        exp_waddr = '0;
        exp_wdata = '0;
        exp_done  = 1'b0;
    endtask

    // Apply one clock's worth of the behavioural rules to the current inputs
    task automatic model_step();
        exp_ar = 1'b0;
        exp_br = 1'b0;
        if (sweep_q.size() != 0) begin
            exp_we    = 1'b1;
            exp_waddr = AW'(sweep_q.pop_front());
            exp_wdata = '0;
            exp_done  = (sweep_q.size() == 0);
        end else if (init_req) begin
            model_fill();
            exp_we   = 1'b0;
            exp_done = 1'b0;
        end else begin
            if (a_valid && b_valid) begin
                exp_ar = last_b;
                exp_br = !last_b;
            end else begin
                exp_ar = a_valid;
                exp_br = b_valid;
            end
            if (exp_ar) begin
                exp_we = (a_rd != '0); exp_waddr = a_rd; exp_wdata = a_data; last_b = 1'b0;
            end else if (exp_br) begin
                exp_we = (b_rd != '0); exp_waddr = b_rd; exp_wdata = b_data; last_b = 1'b1;
            end else begin
                exp_we = 1'b0;
            end
        end
    endtask

    // Entered at posedge+1 with inputs set; checks ready mid-cycle and registers after the edge
    task automatic cycle(input string tag);
        #3;
        model_step();
        chk({tag, "_a_ready"}, 64'(a_ready), 64'(exp_ar));
        chk({tag, "_b_ready"}, 64'(b_ready), 64'(exp_br));
        last_ar = a_ready;
        last_br = b_ready;
        if (a_ready) dut_log = {dut_log, "A"};
        if (b_ready) dut_log = {dut_log, "B"};
        @(posedge clk);
        #1;
        chk({tag, "_rf_we"},     64'(rf_we),     64'(exp_we));
        chk({tag, "_rf_waddr"},  64'(rf_waddr),  64'(exp_waddr));
        chk({tag, "_rf_wdata"},  64'(rf_wdata),  64'(exp_wdata));
        chk({tag, "_init_done"}, 64'(init_done), 64'(exp_done));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; init_req = 1'b0;
        a_valid = 1'b0; a_rd = '0; a_data = '0;
        b_valid = 1'b0; b_rd = '0; b_data = '0;
        last_ar = 1'b0; last_br = 1'b0;
        dut_log = "";
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rf_we", 64'(rf_we), 64'd0);
        chk("rst_rf_waddr", 64'(rf_waddr), 64'd0);
        chk("rst_rf_wdata", 64'(rf_wdata), 64'd0);
        chk("rst_init_done", 64'(init_done), 64'd0);
        rst_n = 1'b1;
        model_reset();

        // Sweep with both requesters pending and a stray init_req: none may be accepted
        a_valid = 1'b1; a_rd = 5'd4; a_data = 32'h1111_1111;
        b_valid = 1'b1; b_rd = 5'd6; b_data = 32'h2222_2222;
        for (int i = 0; i < int'(NREGS) - 1; i++) begin
            init_req = (i == 10);
            cycle("t1_sweep");
        end
        init_req = 1'b0;
        chk_log("t1_no_grant_in_sweep", "");
        chk("t1_done", 64'(init_done), 64'd1);

        // Both valid for four cycles: strict alternation starting with A
        a_rd = 5'd3; a_data = 32'hAAAA_0003;
        b_rd = 5'd7; b_data = 32'hBBBB_0007;
        dut_log = "";
        repeat (4) cycle("t3_rr");
        chk_log("t3_order", "ABAB");

        // A alone
        b_valid = 1'b0;
        a_rd = 5'd5; a_data = 32'hDEAD_BEEF;
        cycle("t2_a_only");
        chk("t2_waddr", 64'(rf_waddr), 64'd5);
        chk("t2_wdata", 64'(rf_wdata), 64'hDEAD_BEEF);

        // B to x0: handshake but no write, still counts for round-robin
        a_valid = 1'b0;
        b_valid = 1'b1; b_rd = 5'd0; b_data = 32'h0000_1234;
        dut_log = "";
        cycle("t4_rd0");
        chk("t4_no_we", 64'(rf_we), 64'd0);
        a_valid = 1'b1; a_rd = 5'd9;  a_data = 32'h0000_0009;
        b_valid = 1'b1; b_rd = 5'd10; b_data = 32'h0000_000A;
        cycle("t4_both");
        chk_log("t4_order", "BA");

        // init_req with both pending: nothing accepted until the sweep completes
        dut_log = "";
        init_req = 1'b1;
        cycle("t5_req");
        init_req = 1'b0;
        for (int i = 0; i < int'(NREGS) - 1; i++) cycle("t5_sweep");
        chk_log("t5_blocked", "");
        chk("t5_done", 64'(init_done), 64'd1);
        repeat (2) cycle("t5_after");
        chk_log("t5_order", "BA");

        // Randomised traffic with protocol-legal holding and occasional re-init
        for (int n = 0; n < 400; n++) begin
            if (!a_valid || last_ar) begin
                a_valid = ($urandom_range(0, 3) != 0);
                a_rd    = AW'($urandom);
                a_data  = $urandom;
            end else if ($urandom_range(0, 7) == 0) begin
                a_valid = 1'b0;
            end
            if (!b_valid || last_br) begin
                b_valid = ($urandom_range(0, 3) != 0);
                b_rd    = AW'($urandom);
                b_data  = $urandom;
            end else if ($urandom_range(0, 7) == 0) begin
                b_valid = 1'b0;
            end
            init_req = ($urandom_range(0, 79) == 0);
            cycle("rnd");
        end
        init_req = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;

        // Reset in the middle of a sweep
        init_req = 1'b1;
        cycle("t6_req");
        init_req = 1'b0;
        for (int i = 0; i < 40 && !(rf_we && rf_waddr == 5'd17); i++) cycle("t6_sweep");
        chk("t6_reach17", 64'(rf_waddr), 64'd17);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_we", 64'(rf_we), 64'd0);
        chk("t6_async_waddr", 64'(rf_waddr), 64'd0);
        chk("t6_async_wdata", 64'(rf_wdata), 64'd0);
        chk("t6_async_done", 64'(init_done), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        cycle("t6_restart");
        chk("t6_first_addr", 64'(rf_waddr), 64'd1);
        repeat (3) cycle("t6_restart");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
